sram_array_rw_ctrl: RTL and testbench
=====================================

Name: sram_array_rw_ctrl

Overview:
- Requester-side controller that drives the R0 (read) and W0 (write) ports of a 1R1W synchronous SRAM macro (default 512x50).
- Presents ready/valid read and write request channels plus a fixed-latency read response.
- Performs an optional post-reset zeroing sweep of the array.
- Forwards write data on same-address read/write collisions and holds read data stable between reads.
- Sits between predictor/table logic and the generated array macro; the parent ties the macro's R0_clk and W0_clk to clock.

Parameters:
DEPTH, 512, number of array entries
AW, 9, address width; DEPTH is at most 2^AW
DW, 50, data width
SHOULD_RESET, 1, 1 = zero every entry after reset; 0 = ready immediately after reset

Ports:
clock  input  1  single clock for controller and macro
reset_n  input  1  asynchronous, active-low reset
w_valid  input  1  write request valid
w_ready  output  1  write request accepted when high with w_valid
w_addr  input  AW  write address
w_data  input  DW  write data
r_valid  input  1  read request valid
r_ready  output  1  read request accepted when high with r_valid
r_addr  input  AW  read address
resp_valid  output  1  one-cycle pulse, read data valid
resp_data  output  DW  read data
R0_en  output  1  to macro read enable
R0_addr  output  AW  to macro read address
R0_data  input  DW  from macro, reflects the address latched at the last R0_en edge
W0_en  output  1  to macro write enable
W0_addr  output  AW  to macro write address
W0_data  output  DW  to macro write data

Behaviour:
- Reset: reset_n is asynchronous and active-low. While reset_n=0:
  - state = SWEEP if SHOULD_RESET, else READY; sweep counter = 0.
  - resp_valid=0, hold register=0, bypass flag=0.
  - R0_en=0, W0_en=0, w_ready=0, r_ready=0.
- State SWEEP:
  - Each cycle: W0_en=1, W0_addr=counter, W0_data=0; counter increments.
  - w_ready=r_ready=0 and R0_en=0; requests are stalled, not dropped.
  - After writing DEPTH-1, go to READY. The sweep takes exactly DEPTH cycles after reset release.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- State READY: w_ready=1 and r_ready=1 every cycle, with no internal backpressure.
- Write fire (w_valid&w_ready): in the same cycle, combinationally, W0_en=1, W0_addr=w_addr, W0_data=w_data. The array is updated at that edge.
- Read fire (r_valid&r_ready): in the same cycle, R0_en=1, R0_addr=r_addr. Latency is 1: resp_valid=1 in the next cycle, for exactly one cycle.
- Back-to-back reads are accepted every cycle and give one response per cycle, in order.
- Collision: a read and a write firing in the same cycle to the same address.
  - Register w_data and set the bypass flag.
  - The next-cycle response returns the new w_data, not R0_data.
  - Different addresses: no bypass.
- Response mux:
  - Response cycle: resp_data = bypass ? bypass register : R0_data.
  - That value is captured into the hold register.
- Hold: in non-response cycles resp_data = hold register. resp_data stays stable until the next response, even if the same location is rewritten or the macro output changes.
- Before the first response after reset, resp_data=0.
- Address width: addresses >= DEPTH are not checked; the caller must not issue them. Bench assertion only.
- No state other than SWEEP/READY. READY is terminal until reset.

Test Plan:
- SHOULD_RESET=1: release reset, hold r_valid=1 with r_addr=0x1FF. Expect r_ready=0 for 512 cycles, W0_en high with W0_addr 0..511 and W0_data=0, then read fires, resp_valid one cycle later, resp_data=0.
- Write addr 0x005 data 0x3_FFFF_0000_1234, then read 0x005 a cycle later. Expect resp_valid exactly 1 cycle after the read fire, resp_data=0x3_FFFF_0000_1234.
- Same-cycle write 0x010 data 0x2AAAA_AAAAAAAA and read 0x010, where the old content is 0x1. Expect resp_data=0x2AAAA_AAAAAAAA. Repeat with read 0x011: expect the old content of 0x011 and the bypass not used.
- Read 0x020 (content 0x7), then write 0x020 with 0x9 and idle 5 cycles. Expect resp_data to remain 0x7 throughout, and a subsequent read returns 0x9.
- Reads to 0x000..0x003 on four consecutive cycles. Expect four consecutive resp_valid pulses with the data in address order.
- Assert reset_n=0 at sweep address 100 for 2 cycles, then release. Expect all outputs at reset values immediately (asynchronous), and the sweep restarts at W0_addr=0 and lasts 512 cycles. With SHOULD_RESET=0, expect w_ready=r_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/sram_array_rw_ctrl_if.sv
// Request/response channels between a table client and sram_array_rw_ctrl.
// The master drives requests; the slave (controller) returns readies and read responses.
interface sram_array_rw_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 50
);
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          r_valid;
  logic          r_ready;
  logic [AW-1:0] r_addr;
  logic          resp_valid;
  logic [DW-1:0] resp_data;

  modport master (
    output w_valid, w_addr, w_data, r_valid, r_addr,
    input  w_ready, r_ready, resp_valid, resp_data
  );

  modport slave (
    input  w_valid, w_addr, w_data, r_valid, r_addr,
    output w_ready, r_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_array_rw_ctrl.sv
// 1R1W SRAM requester: optional zeroing sweep, then read latency 1 with same-address write bypass.
// Stalls both channels during the sweep; afterwards always ready, and resp_data holds between responses.
module sram_array_rw_ctrl #(
  parameter int DEPTH        = 512,
  parameter int AW           = 9,
  parameter int DW           = 50,
  parameter int SHOULD_RESET = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  sram_array_rw_ctrl_if.slave req,
  output logic          R0_en,
  output logic [AW-1:0] R0_addr,
  input  logic [DW-1:0] R0_data,
  output logic          W0_en,
  output logic [AW-1:0] W0_addr,
  output logic [DW-1:0] W0_data
);

  typedef enum logic {ST_SWEEP, ST_READY} state_e;

  localparam state_e RST_STATE = (SHOULD_RESET != 0) ? ST_SWEEP : ST_READY;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          resp_vld_q, resp_vld_d;
  logic          byp_q, byp_d;
  logic [DW-1:0] byp_dat_q, byp_dat_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] resp_dat;
  logic          rdy, w_fire, r_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      resp_vld_q <= 1'b0;
      byp_q      <= 1'b0;
      byp_dat_q  <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_vld_q <= resp_vld_d;
      byp_q      <= byp_d;
      byp_dat_q  <= byp_dat_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Gating with reset_n keeps every enable/ready low while reset is held,
    // even when the reset state is already READY.
    rdy     = reset_n && (state_q == ST_READY);
    w_fire  = rdy && req.w_valid;
    r_fire  = rdy && req.r_valid;
    W0_en   = w_fire;
    W0_addr = req.w_addr;
    W0_data = req.w_data;
    R0_en   = r_fire;
    R0_addr = req.r_addr;

    if (state_q == ST_SWEEP) begin
      W0_en   = reset_n;
      W0_addr = cnt_q;
      W0_data = '0;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end

    // The macro returns pre-write contents on a same-address collision, so the
    // new write data is carried alongside the read instead.
    resp_vld_d = r_fire;
    byp_d      = r_fire && w_fire && (req.r_addr == req.w_addr);
    byp_dat_d  = byp_d ? req.w_data : byp_dat_q;

    resp_dat = hold_q;
    if (resp_vld_q) begin
      resp_dat = byp_q ? byp_dat_q : R0_data;
    end
    hold_d = resp_dat;
  end

  assign req.w_ready    = rdy;
  assign req.r_ready    = rdy;
  assign req.resp_valid = resp_vld_q;
  assign req.resp_data  = resp_dat;

endmodule

// File: tb/tb_sram_array_rw_ctrl.sv
// Directed bench: sweep, write/read, collision bypass, hold, back-to-back reads, mid-sweep reset.
module tb_sram_array_rw_ctrl;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 50;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sram_array_rw_ctrl_if #(.AW(AW), .DW(DW)) rq  ();
  sram_array_rw_ctrl_if #(.AW(AW), .DW(DW)) rq0 ();

  logic          R0_en, W0_en;
  logic [AW-1:0] R0_addr, W0_addr;
  logic [DW-1:0] R0_data, W0_data;

  logic          r0_en_0, w0_en_0;
  logic [AW-1:0] r0_addr_0, w0_addr_0;
  logic [DW-1:0] r0_data_0, w0_data_0;
  assign r0_data_0 = '0;

  sram_array_rw_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SHOULD_RESET(1)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .req     (rq),
    .R0_en   (R0_en),
    .R0_addr (R0_addr),
    .R0_data (R0_data),
    .W0_en   (W0_en),
    .W0_addr (W0_addr),
    .W0_data (W0_data)
  );

  sram_array_rw_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SHOULD_RESET(0)) dut0 (
    .clock   (clk),
    .reset_n (reset_n),
    .req     (rq0),
    .R0_en   (r0_en_0),
    .R0_addr (r0_addr_0),
    .R0_data (r0_data_0),
    .W0_en   (w0_en_0),
    .W0_addr (w0_addr_0),
    .W0_data (w0_data_0)
  );

  // Macro model: read data captured at the R0_en edge (pre-write on collision),
  // then follows the current contents of the latched address.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] rdata_q;
  assign R0_data = rdata_q;

  always @(posedge clk) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) begin
      raddr_q <= R0_addr;
      rdata_q <= mem[R0_addr];
    end else begin
      rdata_q <= mem[raddr_q];
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rq.r_valid === 1'b1)
      assert (int'(rq.r_addr) < DEPTH) else $error("read address out of range");
    if (reset_n === 1'b1 && rq.w_valid === 1'b1)
      assert (int'(rq.w_addr) < DEPTH) else $error("write address out of range");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    rq.w_valid = wv;
    rq.w_addr  = wa;
    rq.w_data  = wd;
    rq.r_valid = rv;
    rq.r_addr  = ra;
  endtask

  // Entered at posedge+1 of sweep cycle 0; leaves at posedge+1 of cycle n.
  task automatic sweep_run(input int n, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!(W0_en === 1'b1 && W0_addr === AW'(k) && W0_data === '0 &&
            rq.w_ready === 1'b0 && rq.r_ready === 1'b0 && R0_en === 1'b0))
        bad++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    reset_n     = 1'b0;
    rq.w_valid  = 1'b0; rq.w_addr  = '0; rq.w_data  = '0;
    rq.r_valid  = 1'b0; rq.r_addr  = '0;
    rq0.w_valid = 1'b0; rq0.w_addr = '0; rq0.w_data = '0;
    rq0.r_valid = 1'b0; rq0.r_addr = '0;

    #2;
    expect_eq("rst_w_ready",    64'(rq.w_ready), 64'd0);
    expect_eq("rst_r_ready",    64'(rq.r_ready), 64'd0);
    expect_eq("rst_resp_valid", 64'(rq.resp_valid), 64'd0);
    expect_eq("rst_resp_data",  64'(rq.resp_data), 64'd0);
    expect_eq("rst_W0_en",      64'(W0_en), 64'd0);
    expect_eq("rst_R0_en",      64'(R0_en), 64'd0);
    expect_eq("rst_nosweep_rdy", 64'(rq0.w_ready), 64'd0);

    // Release with a read already pending; it must stall for the whole sweep.
    @(posedge clk); #1;
    @(posedge clk); #1;
    rq.r_valid = 1'b1;
    rq.r_addr  = 9'h1FF;
    reset_n    = 1'b1;
    #1;
    expect_eq("nosweep_w_ready", 64'(rq0.w_ready), 64'd1);
    expect_eq("nosweep_r_ready", 64'(rq0.r_ready), 64'd1);
    sweep_run(DEPTH, bad);
    expect_eq("sweep1_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    expect_eq("post_sweep_r_ready", 64'(rq.r_ready), 64'd1);
    expect_eq("post_sweep_R0_en",   64'(R0_en), 64'd1);
    expect_eq("post_sweep_R0_addr", 64'(R0_addr), 64'h1FF);
    expect_eq("post_sweep_W0_en",   64'(W0_en), 64'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("sweep_rd_valid", 64'(rq.resp_valid), 64'd1);
    expect_eq("sweep_rd_data",  64'(rq.resp_data), 64'd0);

    // Plain write then read.
    drive(1, 9'h005, 50'h3_FFFF_0000_1234, 0, 0);
    @(negedge clk);
    expect_eq("wr_W0_en",   64'(W0_en), 64'd1);
    expect_eq("wr_W0_addr", 64'(W0_addr), 64'h005);
    expect_eq("wr_W0_data", 64'(W0_data), 64'h3_FFFF_0000_1234);
    expect_eq("resp_pulse_len", 64'(rq.resp_valid), 64'd0);
    drive(0, 0, 0, 1, 9'h005);
    @(negedge clk);
    expect_eq("rd_R0_en", 64'(R0_en), 64'd1);
    expect_eq("rd_no_early_resp", 64'(rq.resp_valid), 64'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("rd5_valid", 64'(rq.resp_valid), 64'd1);
    expect_eq("rd5_data",  64'(rq.resp_data), 64'h3_FFFF_0000_1234);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("rd5_valid_drop", 64'(rq.resp_valid), 64'd0);
    expect_eq("rd5_data_held",  64'(rq.resp_data), 64'h3_FFFF_0000_1234);

    // Collisions: same address bypasses, different address does not.
    drive(1, 9'h010, 50'h1, 0, 0);
    drive(1, 9'h011, 50'h55, 0, 0);
    drive(1, 9'h010, 50'h2AAAA_AAAAAAAA, 1, 9'h010);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("coll_same_valid", 64'(rq.resp_valid), 64'd1);
    expect_eq("coll_same_data",  64'(rq.resp_data), 64'h2AAAA_AAAAAAAA);
    drive(1, 9'h010, 50'h123, 1, 9'h011);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("coll_diff_data", 64'(rq.resp_data), 64'h55);
    drive(0, 0, 0, 1, 9'h010);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("coll_wr_landed", 64'(rq.resp_data), 64'h123);

    // Hold: location rewritten right after its read response.
    drive(1, 9'h020, 50'h7, 0, 0);
    drive(0, 0, 0, 1, 9'h020);
    drive(1, 9'h020, 50'h9, 0, 0);
    @(negedge clk);
    expect_eq("hold_rd_valid", 64'(rq.resp_valid), 64'd1);
    expect_eq("hold_rd_data",  64'(rq.resp_data), 64'h7);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      expect_eq($sformatf("hold_idle%0d", i), 64'(rq.resp_data), 64'h7);
    end
    drive(0, 0, 0, 1, 9'h020);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("hold_reread", 64'(rq.resp_data), 64'h9);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) drive(1, AW'(i), DW'(64'h100 + 64'(i)), 0, 0);
    drive(0, 0, 0, 1, 9'h000);
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) drive(0, 0, 0, 1, AW'(i));
      else       drive(0, 0, 0, 0, 0);
      @(negedge clk);
      expect_eq($sformatf("b2b_valid%0d", i - 1), 64'(rq.resp_valid), 64'd1);
      expect_eq($sformatf("b2b_data%0d", i - 1), 64'(rq.resp_data), 64'h100 + 64'(i - 1));
    end

    // Reset, partial sweep, asynchronous reset at address 100, full restart.
    drive(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    expect_eq("rst2_resp_data",  64'(rq.resp_data), 64'd0);
    expect_eq("rst2_resp_valid", 64'(rq.resp_valid), 64'd0);
    expect_eq("rst2_w_ready",    64'(rq.w_ready), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sweep_run(100, bad);
    expect_eq("sweep2_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    expect_eq("sweep2_at100", 64'(W0_addr), 64'd100);
    reset_n = 1'b0;
    #1;
    expect_eq("midrst_W0_en",   64'(W0_en), 64'd0);
    expect_eq("midrst_R0_en",   64'(R0_en), 64'd0);
    expect_eq("midrst_r_ready", 64'(rq.r_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    expect_eq("rel2_nosweep_rdy", 64'(rq0.w_ready), 64'd1);
    sweep_run(DEPTH, bad);
    expect_eq("sweep3_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    expect_eq("sweep3_done_rdy", 64'(rq.r_ready), 64'd1);
    expect_eq("sweep3_done_W0",  64'(W0_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
